// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared opcode/funct codes, forward-select encodings and
//               hazard helper functions for the MIPS ID-stage controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef logic [1:0] tuse_t;
  typedef logic [1:0] fwd_t;

  // Per-field read descriptor: rd=0 means the field is not a source operand.
  typedef struct packed {
    logic  rd;
    tuse_t tuse;
  } use_t;

  localparam fwd_t FWD_GRF = 2'd0;
  localparam fwd_t FWD_M   = 2'd1;
  localparam fwd_t FWD_W   = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADDU  = 6'h21;

  function automatic logic gpr_hazard(input logic [4:0] f, input use_t u,
                                      input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                      input logic [4:0] a3_m, input logic [1:0] tnew_m);
    return u.rd && (f != 5'd0) &&
           (((f == a3_e) && (tnew_e > u.tuse)) || ((f == a3_m) && (tnew_m > u.tuse)));
  endfunction

  function automatic fwd_t fwd_select(input logic [4:0] f,
                                      input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                      input logic [4:0] a3_w, input logic regwrite_w);
    if ((f != 5'd0) && (f == a3_m) && (tnew_m == 2'd0)) return FWD_M;
    if ((f != 5'd0) && (f == a3_w) && regwrite_w)       return FWD_W;
    return FWD_GRF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_cnt.sv
// ============================================================================
// Module      : md_busy_cnt
// Description : Mult/div occupancy counter; md_busy is a registered flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_e,
  input  logic is_div_e,
  output logic md_busy
);

  logic [CNT_W-1:0] r_count;
  logic             r_md_busy;
  logic [CNT_W-1:0] w_load;

  assign w_load = is_div_e ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // The flag is registered alongside the count so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_md_busy <= 1'b0;
    end else if (start_e) begin
      r_count   <= w_load;
      r_md_busy <= (w_load != '0);
    end else if (r_count != '0) begin
      r_count   <= r_count - CNT_W'(1);
      r_md_busy <= (r_count != CNT_W'(1));
    end
  end

  assign md_busy = r_md_busy;

  a_no_restart: assert property (@(posedge clk) disable iff (!reset) !(start_e && r_md_busy));

endmodule

`default_nettype wire

// File: rtl/md_hazard_ctrl.sv
// ============================================================================
// Module      : md_hazard_ctrl
// Description : ID-stage hazard/forwarding control with mult/div busy tracking.
//               Optional stall-cycle counter enabled by macro STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic [4:0]  a3_e,
  input  logic [1:0]  tnew_e,
  input  logic [4:0]  a3_m,
  input  logic [1:0]  tnew_m,
  input  logic [4:0]  a3_w,
  input  logic        regwrite_w,
  input  logic        start_e,
  input  logic        is_div_e,
  output logic [1:0]  forward_rsd,
  output logic [1:0]  forward_rtd,
  output logic        stall,
  output logic        id_ex_clr,
  output logic        md_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  use_t       w_rs_use;
  use_t       w_rt_use;
  logic       w_is_md;
  logic       w_gpr_stall;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_unused_bits;

  assign w_op          = instr_d[31:26];
  assign w_rs          = instr_d[25:21];
  assign w_rt          = instr_d[20:16];
  assign w_funct       = instr_d[5:0];
  assign w_unused_bits = ^instr_d[15:6];

  always_comb begin
    w_rs_use = '{rd: 1'b0, tuse: 2'd0};
    w_rt_use = '{rd: 1'b0, tuse: 2'd0};
    w_is_md  = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        case (w_funct)
          F_JR, F_JALR:         w_rs_use = '{rd: 1'b1, tuse: 2'd0};
          F_SLL, F_SRL, F_SRA:  w_rt_use = '{rd: 1'b1, tuse: 2'd1};
          F_MFHI, F_MFLO:       w_is_md  = 1'b1;
          F_MTHI, F_MTLO: begin
            w_rs_use = '{rd: 1'b1, tuse: 2'd1};
            w_is_md  = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            w_rs_use = '{rd: 1'b1, tuse: 2'd1};
            w_rt_use = '{rd: 1'b1, tuse: 2'd1};
            w_is_md  = 1'b1;
          end
          default: begin
            w_rs_use = '{rd: 1'b1, tuse: 2'd1};
            w_rt_use = '{rd: 1'b1, tuse: 2'd1};
          end
        endcase
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ: w_rs_use = '{rd: 1'b1, tuse: 2'd0};
      OP_BEQ, OP_BNE: begin
        w_rs_use = '{rd: 1'b1, tuse: 2'd0};
        w_rt_use = '{rd: 1'b1, tuse: 2'd0};
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        w_rs_use = '{rd: 1'b1, tuse: 2'd1};
      OP_SB, OP_SH, OP_SW: begin
        w_rs_use = '{rd: 1'b1, tuse: 2'd1};
        w_rt_use = '{rd: 1'b1, tuse: 2'd2};
      end
      default: ;
    endcase
  end

  assign w_gpr_stall = gpr_hazard(w_rs, w_rs_use, a3_e, tnew_e, a3_m, tnew_m) |
                       gpr_hazard(w_rt, w_rt_use, a3_e, tnew_e, a3_m, tnew_m);
  // start_e covers the issue cycle, before md_busy has registered.
  assign w_md_stall  = w_is_md && (start_e || md_busy);
  assign w_stall     = w_gpr_stall | w_md_stall;

  assign stall       = w_stall;
  assign id_ex_clr   = w_stall;
  assign forward_rsd = fwd_select(w_rs, a3_m, tnew_m, a3_w, regwrite_w);
  assign forward_rtd = fwd_select(w_rt, a3_m, tnew_m, a3_w, regwrite_w);

  md_busy_cnt #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .start_e  (start_e),
    .is_div_e (is_div_e),
    .md_busy  (md_busy)
  );

`ifdef STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_md_hazard_ctrl.sv
// ============================================================================
// Module      : tb_md_hazard_ctrl
// Description : Directed self-checking bench for md_hazard_ctrl (STALL_CNT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_hazard_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic [4:0]  a3_e, a3_m, a3_w;
  logic [1:0]  tnew_e, tnew_m;
  logic        regwrite_w, start_e, is_div_e;
  logic [1:0]  forward_rsd, forward_rtd;
  logic        stall, id_ex_clr, md_busy;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] exp_scnt;
`endif

  typedef struct {
    string      tag;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       st;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  md_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_d     (instr_d),
    .a3_e        (a3_e),
    .tnew_e      (tnew_e),
    .a3_m        (a3_m),
    .tnew_m      (tnew_m),
    .a3_w        (a3_w),
    .regwrite_w  (regwrite_w),
    .start_e     (start_e),
    .is_div_e    (is_div_e),
    .forward_rsd (forward_rsd),
    .forward_rtd (forward_rtd),
    .stall       (stall),
    .id_ex_clr   (id_ex_clr),
    .md_busy     (md_busy)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0010};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [4:0] ae, input logic [1:0] te,
                       input logic [4:0] am, input logic [1:0] tm, input logic [4:0] aw,
                       input logic rw, input logic st, input logic dv);
    instr_d = ins; a3_e = ae; tnew_e = te; a3_m = am; tnew_m = tm;
    a3_w = aw; regwrite_w = rw; start_e = st; is_div_e = dv;
  endtask

  task automatic expect_now(input string tag, input logic [1:0] efrs, input logic [1:0] efrt,
                            input logic est, input logic eb);
    exp_t e;
    e.tag = tag; e.frs = efrs; e.frt = efrt; e.st = est; e.busy = eb;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    n_vec++;
    assert (forward_rsd === e.frs) else begin
      n_err++; $error("FAIL %s forward_rsd got %0d expected %0d", e.tag, forward_rsd, e.frs);
    end
    n_vec++;
    assert (forward_rtd === e.frt) else begin
      n_err++; $error("FAIL %s forward_rtd got %0d expected %0d", e.tag, forward_rtd, e.frt);
    end
    n_vec++;
    assert (stall === e.st) else begin
      n_err++; $error("FAIL %s stall got %b expected %b", e.tag, stall, e.st);
    end
    n_vec++;
    assert (id_ex_clr === e.st) else begin
      n_err++; $error("FAIL %s id_ex_clr got %b expected %b", e.tag, id_ex_clr, e.st);
    end
    n_vec++;
    assert (md_busy === e.busy) else begin
      n_err++; $error("FAIL %s md_busy got %b expected %b", e.tag, md_busy, e.busy);
    end
`ifdef STALL_CNT_EN
    n_vec++;
    assert (stall_cnt === exp_scnt) else begin
      n_err++; $error("FAIL %s stall_cnt got %0h expected %0h", e.tag, stall_cnt, exp_scnt);
    end
`endif
  endtask

  // One clock cycle: drive after the falling edge, check, then let the rising edge hit.
  task automatic step(input string tag, input logic [31:0] ins,
                      input logic [4:0] ae, input logic [1:0] te,
                      input logic [4:0] am, input logic [1:0] tm,
                      input logic [4:0] aw, input logic rw, input logic st, input logic dv,
                      input logic [1:0] efrs, input logic [1:0] efrt,
                      input logic est, input logic eb);
    @(negedge clk);
    drive(ins, ae, te, am, tm, aw, rw, st, dv);
    expect_now(tag, efrs, efrt, est, eb);
`ifdef STALL_CNT_EN
    if (est && reset) exp_scnt = exp_scnt + 32'd1;
`endif
  endtask

  logic [31:0] nop, addu_dep, mflo_i, mfhi_i, beq12;

  initial begin
    n_vec = 0; n_err = 0;
`ifdef STALL_CNT_EN
    exp_scnt = '0;
`endif
    nop      = 32'd0;
    addu_dep = rtype(F_ADDU, 5'd3, 5'd5, 5'd4);
    mflo_i   = rtype(F_MFLO, 5'd0, 5'd0, 5'd2);
    mfhi_i   = rtype(F_MFHI, 5'd0, 5'd0, 5'd2);
    beq12    = itype(OP_BEQ, 5'd1, 5'd2);
    reset = 1'b0;
    drive(nop, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    expect_now("reset", 0, 0, 0, 0);
    reset = 1'b1;

    step("beq_fwd_m",  beq12,    0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("lw_in_e",    addu_dep, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("dep_in_m",   addu_dep, 0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0);
    step("dep_in_w",   addu_dep, 0, 0, 0, 0, 3, 1, 0, 0, 2, 0, 0, 0);
    step("tnew_eq_tu", addu_dep, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sw_rt_t2",   itype(OP_SW, 5'd0, 5'd3), 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sw_rt_t3",   itype(OP_SW, 5'd0, 5'd3), 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("beq_m_t1",   itype(OP_BEQ, 5'd3, 5'd0), 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    step("prio_m_w",   rtype(F_ADDU, 5'd7, 5'd7, 5'd8), 0, 0, 7, 0, 7, 1, 0, 0, 1, 1, 0, 0);
    step("rt_fwd_w",   rtype(F_ADDU, 5'd0, 5'd9, 5'd8), 0, 0, 0, 0, 9, 1, 0, 0, 0, 2, 0, 0);
    step("w_no_we",    rtype(F_ADDU, 5'd0, 5'd9, 5'd8), 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    step("zero_reg",   rtype(F_ADDU, 5'd0, 5'd0, 5'd6), 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    step("mult_start", mflo_i,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step("mult_b1",    mflo_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mult_b2",    mflo_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mult_b3_alu", addu_dep, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("mult_b4",    mflo_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mult_b5",    mflo_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mult_done",  mflo_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step("div_start",  mfhi_i,   0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    step("div_b1",     mfhi_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("div_b2",     mfhi_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("div_b3",     mfhi_i,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    drive(mfhi_i, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("div_b4", 0, 0, 1, 1);
    reset = 1'b0;
`ifdef STALL_CNT_EN
    exp_scnt = '0;
`endif
    expect_now("div_async_rst", 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    step("div_after_rst", mfhi_i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle_after_rst", nop,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef STALL_CNT_EN
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    exp_scnt = 32'hFFFF_FFFE;
    step("wrap_s1", addu_dep, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wrap_s2", addu_dep, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wrap_s3", addu_dep, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("wrap_chk", nop,     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++; $error("FAIL scoreboard_drain left %0d expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
